cam_frame_capture: RTL
======================

Name: cam_frame_capture

Overview:
- Parametrised successor to the single-format OV7670 capture block.
- Samples the camera byte bus on PCLK and assembles two-byte pixels (RGB565 or RGB444) into RGB332.
- Drives a frame-buffer write port with the pixel and its X/Y address.
- Counts red and blue pixels in a programmable row window and reports a per-frame colour verdict to the navigation FSM.

Parameters:
- FMT, 0, input pixel format: 0 = RGB565, 1 = RGB444 (xRGB).
- MAX_X, 176, pixels per line that are written; later pixels are dropped.
- MAX_Y, 144, lines per frame that are written; later lines are dropped.
- COORD_W, 10, width of X and Y.
- SAMPLE_Y0, 72, first line of the classification window (inclusive).
- SAMPLE_Y1, 73, last line of the classification window (inclusive).
- THRESH, 100, minimum class count for a verdict (strictly greater than).
- CNT_W, 12, width of the class counters; counters saturate.

Ports:
- PCLK  in  1  camera pixel clock; the only clock.
- RESET  in  1  synchronous, active-high reset.
- D  in  8  camera data byte.
- VSYNC  in  1  frame sync, active high; a rising edge starts a frame.
- HREF  in  1  line valid.
- PIXEL_COLOR  out  8  RGB332 pixel, valid when W_EN = 1.
- W_EN  out  1  one-cycle write strobe.
- X  out  COORD_W  column address of PIXEL_COLOR.
- Y  out  COORD_W  row address of PIXEL_COLOR.
- COLOR_RESULT  out  2  frame verdict: 00 none, 01 red, 10 blue, 11 reserved.
- RESULT_VALID  out  1  one-cycle pulse when COLOR_RESULT updates.
- LINE_ERR  out  1  sticky flag: a line ended with an odd byte count; cleared at frame start.

Behaviour:
- Edge detection:
  - VSYNC and HREF are registered once (last_vsync, last_href).
  - Edges are taken from the current sample against the registered value.
- FSM states:
  - IDLE: after reset. Waits for a VSYNC rise and ignores all HREF activity, so a partial frame after reset is never written.
  - WAIT_LINE: waits for HREF = 1.
  - BYTE0: latches D as the first byte.
  - BYTE1: latches D as the second byte and assembles the pixel.
- Transitions:
  - BYTE0 and BYTE1 alternate while HREF = 1.
  - HREF fall moves to WAIT_LINE.
  - A VSYNC rise in any non-IDLE state sets X = 0, Y = 0, clears LINE_ERR, moves to WAIT_LINE and discards any partial pixel.
- Conversion to RGB332:
  - RGB565: R = b0[7:5], G = b0[2:0], B = b1[4:3].
  - RGB444: R = b0[3:1], G = b1[7:5], B = b1[3:2].
- Write timing:
  - W_EN = 1 on the PCLK cycle after BYTE1, only when X < MAX_X and Y < MAX_Y.
  - PIXEL_COLOR, X and Y are stable in that cycle.
  - X increments the cycle after the strobe.
  - X saturates at MAX_X; no wrap.
- HREF fall:
  - Y increments and X clears.
  - If the FSM is in BYTE1 (the first byte is pending), LINE_ERR is set and the half pixel is dropped.
  - Y saturates at MAX_Y.
- Classification (combinational, on the assembled RGB332 pixel):
  - red when R >= 4, G <= 1, B <= 1.
  - blue when B >= 2, R <= 1, G <= 2.
  - otherwise neither class.
- Counting: on each assembled pixel with SAMPLE_Y0 <= Y <= SAMPLE_Y1, the matching counter increments, saturating at 2^CNT_W-1.
- Verdict (on the VSYNC rise that ends a frame, only if the previous state was not IDLE):
  - 01 if red > THRESH and red >= blue.
  - else 10 if blue > THRESH.
  - else 00.
  - RESULT_VALID pulses for one cycle, then both counters clear.
- Reset values:
  - W_EN = 0, PIXEL_COLOR = 0, X = 0, Y = 0.
  - COLOR_RESULT = 00, RESULT_VALID = 0, LINE_ERR = 0.
  - Counters = 0, state = IDLE.
- Reset takes priority over every edge event, including reset mid-line.

Optional Feature:
CAM_OVERLAY_EN
- Defined: PIXEL_COLOR is replaced by the class colour: red 8'hE0, blue 8'h03, none 8'h00. In window rows, matched pixels become 8'h1C (green) so the sample band is visible on the VGA debug display.
- Undefined: PIXEL_COLOR carries the converted pixel unchanged.
- Counting and the verdict are identical in both cases.

Decomposition:
- Package cam_pkg:
  - FMT_RGB565 / FMT_RGB444 constants.
  - COLOR_RESULT codes (RES_NONE, RES_RED, RES_BLUE).
  - Overlay colour constants.
  - FSM state encoding.
- Sub-module cam_pixel_classify: combinational RGB332 -> {is_red, is_blue}, with thresholds held in cam_pkg; shared with the later shape detector.

Test Plan:
- Reset, then HREF lines with no VSYNC -> W_EN never asserts; after the first VSYNC rise, line 0 writes start at X = 0, Y = 0.
- FMT = 0, bytes 8'hF8, 8'h00 -> W_EN pulse one cycle after the second byte, PIXEL_COLOR = 8'hE0, X = 0, then X = 1 on the next pixel.
- FMT = 1, bytes 8'h00, 8'h0F -> PIXEL_COLOR = 8'h03.
- Line of 181 pixels -> exactly 176 W_EN pulses, X stops at 176; at HREF fall Y = 1, X = 0.
- HREF falls after 7 bytes -> 3 writes, LINE_ERR = 1; the next VSYNC rise clears LINE_ERR.
- Rows 72–73 each with 60 red and 10 blue pixels, then a VSYNC rise -> RESULT_VALID pulse, COLOR_RESULT = 01.
  - Repeat with 40 red per row -> COLOR_RESULT = 00.
  - Assert RESET mid-row -> counters are 0 and no RESULT_VALID at the next VSYNC rise.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture path: input formats, verdict codes,
// overlay colours, colour-class thresholds, FSM states and the RGB332 packer.
package cam_pkg;

  localparam int FMT_RGB565 = 0;
  localparam int FMT_RGB444 = 1;

  typedef enum logic [1:0] {
    RES_NONE = 2'b00,
    RES_RED  = 2'b01,
    RES_BLUE = 2'b10
  } cam_result_e;

  localparam logic [7:0] OVL_RED  = 8'hE0;
  localparam logic [7:0] OVL_BLUE = 8'h03;
  localparam logic [7:0] OVL_NONE = 8'h00;
  localparam logic [7:0] OVL_MARK = 8'h1C;

  // Colour-class thresholds on RGB332 fields
  localparam logic [2:0] RED_R_MIN  = 3'd4;
  localparam logic [2:0] RED_G_MAX  = 3'd1;
  localparam logic [1:0] RED_B_MAX  = 2'd1;
  localparam logic [1:0] BLUE_B_MIN = 2'd2;
  localparam logic [2:0] BLUE_R_MAX = 3'd1;
  localparam logic [2:0] BLUE_G_MAX = 3'd2;

  // State name = byte expected on the next HREF-high sample
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_LINE,
    ST_BYTE0,
    ST_BYTE1
  } cam_state_e;

  function automatic logic [7:0] to_rgb332(input int fmt, input logic [7:0] b0,
                                           input logic [7:0] b1);
    if (fmt == FMT_RGB444) return {b0[3:1], b1[7:5], b1[3:2]};
    return {b0[7:5], b0[2:0], b1[4:3]};
  endfunction

endpackage

// File: rtl/cam_pixel_classify.sv
// Combinational RGB332 colour classifier (red / blue / neither).
module cam_pixel_classify
  import cam_pkg::*;
(
  input  logic [7:0] pixel,
  output logic       is_red,
  output logic       is_blue
);

  logic [2:0] r;
  logic [2:0] g;
  logic [1:0] b;

  assign {r, g, b} = pixel;

  assign is_red  = (r >= RED_R_MIN) && (g <= RED_G_MAX) && (b <= RED_B_MAX);
  assign is_blue = (b >= BLUE_B_MIN) && (r <= BLUE_R_MAX) && (g <= BLUE_G_MAX);

endmodule

// File: rtl/cam_frame_capture.sv
// Camera byte-bus capture: assembles two-byte pixels into RGB332, drives a
// frame-buffer write port and reports a per-frame red/blue verdict.
// Optional macro CAM_OVERLAY_EN replaces PIXEL_COLOR with class colours.
module cam_frame_capture
  import cam_pkg::*;
#(
  parameter int FMT       = 0,
  parameter int MAX_X     = 176,
  parameter int MAX_Y     = 144,
  parameter int COORD_W   = 10,
  parameter int SAMPLE_Y0 = 72,
  parameter int SAMPLE_Y1 = 73,
  parameter int THRESH    = 100,
  parameter int CNT_W     = 12
) (
  input  logic               PCLK,
  input  logic               RESET,
  input  logic [7:0]         D,
  input  logic               VSYNC,
  input  logic               HREF,
  output logic [7:0]         PIXEL_COLOR,
  output logic               W_EN,
  output logic [COORD_W-1:0] X,
  output logic [COORD_W-1:0] Y,
  output logic [1:0]         COLOR_RESULT,
  output logic               RESULT_VALID,
  output logic               LINE_ERR
);

  localparam logic [COORD_W-1:0] MAX_X_C  = COORD_W'(MAX_X);
  localparam logic [COORD_W-1:0] MAX_Y_C  = COORD_W'(MAX_Y);
  localparam logic [COORD_W-1:0] WIN_Y0_C = COORD_W'(SAMPLE_Y0);
  localparam logic [COORD_W-1:0] WIN_Y1_C = COORD_W'(SAMPLE_Y1);
  localparam logic [CNT_W-1:0]   THRESH_C = CNT_W'(THRESH);

  cam_state_e       state, state_next;
  logic             last_vsync, last_href;
  logic             vsync_rise, href_fall;
  logic             latch_b0, assemble, drop_half, frame_start, frame_end, line_end;
  logic             pix_done;
  logic [7:0]       byte0;
  logic [7:0]       pix_asm, pix_out;
  logic             is_red, is_blue, in_window;
  logic [CNT_W-1:0] red_cnt, blue_cnt;
  cam_result_e      verdict;

  assign vsync_rise = VSYNC & ~last_vsync;
  assign href_fall  = ~HREF & last_href;
  assign line_end   = href_fall && (state != ST_IDLE) && !vsync_rise;
  assign pix_asm    = to_rgb332(FMT, byte0, D);
  assign in_window  = (Y >= WIN_Y0_C) && (Y <= WIN_Y1_C);

  cam_pixel_classify u_classify (
    .pixel   (pix_asm),
    .is_red  (is_red),
    .is_blue (is_blue)
  );

`ifdef CAM_OVERLAY_EN
  // Overlay colour: class colour, or green marker for matches in the window
  always_comb begin
    pix_out = OVL_NONE;
    if ((is_red || is_blue) && in_window) pix_out = OVL_MARK;
    else if (is_red)                      pix_out = OVL_RED;
    else if (is_blue)                     pix_out = OVL_BLUE;
  end
`else
  assign pix_out = pix_asm;
`endif

  // Frame verdict from the accumulated class counts
  always_comb begin
    verdict = RES_NONE;
    if ((red_cnt > THRESH_C) && (red_cnt >= blue_cnt)) verdict = RES_RED;
    else if (blue_cnt > THRESH_C)                      verdict = RES_BLUE;
  end

  // FSM state register
  always_ff @(posedge PCLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state and per-cycle control decode; VSYNC rise overrides line activity
  always_comb begin
    state_next  = state;
    latch_b0    = 1'b0;
    assemble    = 1'b0;
    drop_half   = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    if (vsync_rise) begin
      state_next  = ST_WAIT_LINE;
      frame_start = 1'b1;
      frame_end   = (state != ST_IDLE);
    end else begin
      case (state)
        ST_IDLE: state_next = ST_IDLE;
        ST_WAIT_LINE, ST_BYTE0: begin
          if (HREF) begin
            latch_b0   = 1'b1;
            state_next = ST_BYTE1;
          end else begin
            state_next = ST_WAIT_LINE;
          end
        end
        ST_BYTE1: begin
          if (HREF) begin
            assemble   = 1'b1;
            state_next = ST_BYTE0;
          end else begin
            drop_half  = 1'b1;
            state_next = ST_WAIT_LINE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Datapath: edge registers, write port, coordinates, line error, verdict
  always_ff @(posedge PCLK) begin
    if (RESET) begin
      last_vsync   <= 1'b0;
      last_href    <= 1'b0;
      byte0        <= '0;
      PIXEL_COLOR  <= '0;
      W_EN         <= 1'b0;
      pix_done     <= 1'b0;
      X            <= '0;
      Y            <= '0;
      LINE_ERR     <= 1'b0;
      COLOR_RESULT <= RES_NONE;
      RESULT_VALID <= 1'b0;
    end else begin
      last_vsync   <= VSYNC;
      last_href    <= HREF;
      W_EN         <= 1'b0;
      pix_done     <= 1'b0;
      RESULT_VALID <= 1'b0;
      if (latch_b0) byte0 <= D;
      if (assemble) begin
        PIXEL_COLOR <= pix_out;
        W_EN        <= (X < MAX_X_C) && (Y < MAX_Y_C);
        pix_done    <= 1'b1;
      end
      // X advances the cycle after the strobe; line/frame boundaries win over that
      if (frame_start) begin
        X        <= '0;
        Y        <= '0;
        LINE_ERR <= 1'b0;
      end else if (line_end) begin
        X <= '0;
        if (Y < MAX_Y_C) Y <= Y + 1'b1;
        if (drop_half) LINE_ERR <= 1'b1;
      end else if (pix_done && (X < MAX_X_C)) begin
        X <= X + 1'b1;
      end
      if (frame_end) begin
        COLOR_RESULT <= verdict;
        RESULT_VALID <= 1'b1;
      end
    end
  end

  // Saturating class counters over the window rows, cleared at frame end
  always_ff @(posedge PCLK) begin
    if (RESET || frame_end) begin
      red_cnt  <= '0;
      blue_cnt <= '0;
    end else if (assemble && in_window) begin
      if (is_red && (red_cnt != '1))   red_cnt  <= red_cnt + 1'b1;
      if (is_blue && (blue_cnt != '1)) blue_cnt <= blue_cnt + 1'b1;
    end
  end

endmodule
